reg_op_sequencer: RTL and testbench

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

---
 rtl/reg_op_pkg.sv | 21 ++
 rtl/reg_op_alu.sv | 34 +++
 rtl/reg_op_sequencer.sv | 116 +++++++++++
 tb/tb_reg_op_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_op_pkg.sv
// reg_op_pkg: shared widths, opcodes and sequencer state encoding for the register-op sequencer.
package reg_op_pkg;
  localparam int DEFAULT_DATA_WIDTH = 18;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_LDI = 3'b110,
    OP_CMP = 3'b111
  } op_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/reg_op_alu.sv
// reg_op_alu: combinational result and zero/carry flags for one register-file operation.
module reg_op_alu
  import reg_op_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  op_e                   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  carry
);
  logic [DATA_WIDTH:0] sum, diff;
  // The extra top bit of the widened difference is the unsigned borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD:         {carry, result} = sum;
      OP_SUB, OP_CMP: {carry, result} = diff;
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_MOV:         result = a;
      OP_LDI:         result = imm;
      default:        result = '0;
    endcase
    zero = (result == '0);
  end
endmodule

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: accepts one register op, reads operands, writes back the result and reports it.
module reg_op_sequencer
  import reg_op_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_dest,
  input  logic [ADDR_WIDTH-1:0] cmd_src1,
  input  logic [ADDR_WIDTH-1:0] cmd_src2,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_zero,
  output logic                  resp_carry,
  output logic                  rf_enable,
  output logic                  rf_load,
  output logic [ADDR_WIDTH-1:0] rf_reg_to_read1,
  output logic [ADDR_WIDTH-1:0] rf_reg_to_read2,
  output logic [ADDR_WIDTH-1:0] rf_reg_to_write,
  output logic [DATA_WIDTH-1:0] rf_data_to_write,
  input  logic [DATA_WIDTH-1:0] rf_data_to_read1,
  input  logic [DATA_WIDTH-1:0] rf_data_to_read2
);
  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d, res_q, res_d;
  logic                  zero_q, zero_d, carry_q, carry_d;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_zero, alu_carry;

  reg_op_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (op_q),
    .a      (rf_data_to_read1),
    .b      (rf_data_to_read2),
    .imm    (imm_q),
    .result (alu_res),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dest_d  = dest_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    imm_d   = imm_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = READ;
        op_d    = op_e'(cmd_op);
        dest_d  = cmd_dest;
        src1_d  = cmd_src1;
        src2_d  = cmd_src2;
        imm_d   = cmd_imm;
      end
      READ: state_d = EXEC;
      EXEC: begin
        state_d = DONE;
        res_d   = alu_res;
        zero_d  = alu_zero;
        carry_d = alu_carry;
      end
      DONE: state_d = resp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      dest_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // Register-file strobes decode straight from state, so an async reset in EXEC cancels the write.
  assign cmd_ready        = (state_q == IDLE);
  assign resp_valid       = (state_q == DONE);
  assign resp_data        = res_q;
  assign resp_zero        = zero_q;
  assign resp_carry       = carry_q;
  assign rf_enable        = (state_q == READ) || (state_q == EXEC);
  assign rf_load          = (state_q == EXEC) && (op_q != OP_CMP);
  assign rf_reg_to_read1  = src1_q;
  assign rf_reg_to_read2  = src2_q;
  assign rf_reg_to_write  = dest_q;
  assign rf_data_to_write = (state_q == EXEC) ? alu_res : '0;
endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer: randomized and directed scoreboard bench with a behavioural register-file model.
module tb_reg_op_sequencer;
  localparam int DW = 18;
  localparam int AW = 4;
  localparam longint MASK = (64'd1 << DW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid, cmd_ready, resp_valid, resp_ready, resp_zero, resp_carry;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_dest, cmd_src1, cmd_src2;
  logic [DW-1:0] cmd_imm, resp_data, rf_data_to_write, rf_data_to_read1, rf_data_to_read2;
  logic          rf_enable, rf_load;
  logic [AW-1:0] rf_reg_to_read1, rf_reg_to_read2, rf_reg_to_write;

  always #5 clock = ~clock;

  reg_op_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dest(cmd_dest), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_imm(cmd_imm),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_carry(resp_carry),
    .rf_enable(rf_enable), .rf_load(rf_load),
    .rf_reg_to_read1(rf_reg_to_read1), .rf_reg_to_read2(rf_reg_to_read2),
    .rf_reg_to_write(rf_reg_to_write), .rf_data_to_write(rf_data_to_write),
    .rf_data_to_read1(rf_data_to_read1), .rf_data_to_read2(rf_data_to_read2)
  );

  // Register file attached to the sequencer: registered reads, write on rf_load, never reset.
  logic [DW-1:0] regs [16];
  always @(posedge clock) begin
    if (rf_enable) begin
      rf_data_to_read1 <= regs[rf_reg_to_read1];
      rf_data_to_read2 <= regs[rf_reg_to_read2];
    end
    if (rf_load) regs[rf_reg_to_write] <= rf_data_to_write;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    longint d;
    bit     z;
    bit     c;
    int     acc;
  } exp_t;

  exp_t   q[$];
  longint mreg [16];
  int     checks = 0, fails = 0;
  int     load_bad = 0, last_acc = 0, last_op = 0;
  longint last_data = 0;
  bit     last_z = 0, last_c = 0, rand_ready = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    fails++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference: architectural effect of one command on the 16-entry register array.
  function automatic exp_t model(input int op, input int d, input int s1, input int s2, input longint imm);
    exp_t e;
    longint a = mreg[s1], b = mreg[s2], r = 0;
    bit c = 0;
    case (op)
      0: begin r = a + b; c = (r > MASK); r = r & MASK; end
      1, 7: begin c = (a < b); r = (a - b) & MASK; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a;
      default: r = imm & MASK;
    endcase
    if (op != 7) mreg[d] = r;
    e.d = r;
    e.z = (r == 0);
    e.c = c;
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input int op, input int d, input int s1, input int s2, input longint imm, input bit push);
    int n = 0;
    exp_t e;
    cmd_op = op[2:0]; cmd_dest = d[AW-1:0]; cmd_src1 = s1[AW-1:0]; cmd_src2 = s2[AW-1:0];
    cmd_imm = imm[DW-1:0];
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge clock); n++; end
    if (!cmd_ready) begin
      fail_now("accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    last_acc = cyc;
    last_op = op;
    if (push) begin
      e = model(op, d, s1, s2, imm);
      e.acc = cyc;
      q.push_back(e);
    end
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_dest = 4'($urandom); cmd_src1 = 4'($urandom);
    cmd_src2 = 4'($urandom); cmd_imm = 18'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !cmd_ready) && n < 200) begin @(negedge clock); n++; end
    if (n >= 200) fail_now("idle_timeout");
  endtask

  initial forever begin
    @(negedge clock);
    if (rand_ready) resp_ready = ($urandom_range(0, 3) != 0);
  end

  initial forever begin
    @(negedge clock);
    #2;
    if (rf_load && last_op == 7) load_bad++;
  end

  // Monitor: latency on response arrival, stability while stalled, value on handshake.
  initial begin
    bit pv = 0, phs = 0;
    longint pd = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin pv = 0; continue; end
      if (resp_valid && !pv && q.size() != 0) chk("latency", cyc - q[0].acc, 3);
      if (resp_valid && pv && !phs) chk("hold_data", resp_data, pd);
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) fail_now("unexpected_resp");
        else begin
          e = q.pop_front();
          chk("resp_data", resp_data, e.d);
          chk("resp_zero", resp_zero, e.z);
          chk("resp_carry", resp_carry, e.c);
          last_data = resp_data; last_z = resp_zero; last_c = resp_carry;
        end
      end
      pv = resp_valid;
      phs = resp_valid && resp_ready;
      pd = resp_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    cmd_valid = 0; cmd_op = 0; cmd_dest = 0; cmd_src1 = 0; cmd_src2 = 0; cmd_imm = 0;
    resp_ready = 1;
    @(negedge clock);
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_flags", {resp_zero, resp_carry}, 0);
    chk("rst_rf_strobes", {rf_enable, rf_load}, 0);
    chk("rst_rf_addrs", {rf_reg_to_read1, rf_reg_to_read2, rf_reg_to_write}, 0);
    chk("rst_rf_wdata", rf_data_to_write, 0);
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 16; i++) send(6, i, 0, 0, longint'($urandom), 1);
    wait_idle();
    send(6, 1, 0, 0, 'h3FFFF, 1);
    send(6, 2, 0, 0, 'h00001, 1);
    send(0, 3, 1, 2, 0, 1);
    wait_idle();
    chk("add_wrap_data", last_data, 0);
    chk("add_wrap_flags", {last_z, last_c}, 2'b11);
    send(5, 10, 3, 0, 0, 1);
    wait_idle();
    chk("add_wrap_readback", last_data, 0);
    send(6, 1, 0, 0, 5, 1);
    send(6, 2, 0, 0, 3, 1);
    send(1, 4, 2, 1, 0, 1);
    wait_idle();
    chk("sub_borrow_data", last_data, 'h3FFFE);
    chk("sub_borrow_flags", {last_z, last_c}, 2'b01);
    send(6, 5, 0, 0, 'h1234, 1);
    send(7, 5, 5, 5, 0, 1);
    wait_idle();
    chk("cmp_flags", {last_z, last_c}, 2'b10);
    send(5, 11, 5, 0, 0, 1);
    wait_idle();
    chk("cmp_dest_kept", last_data, 'h1234);
    rand_ready = 0;
    resp_ready = 0;
    send(4, 13, 1, 2, 0, 1);
    for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      cmd_valid = 1; cmd_op = 3'd6; cmd_dest = 4'd13; cmd_imm = 18'h15A5A;
      #2;
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_resp_valid", resp_valid, 1);
    end
    @(negedge clock);
    cmd_valid = 0;
    resp_ready = 1;
    wait_idle();
    send(5, 14, 13, 0, 0, 1);
    wait_idle();
    chk("stall_ignored_cmd", last_data, 'h6);
    send(6, 6, 0, 0, 'h155, 1);
    wait_idle();
    send(6, 6, 0, 0, 'h2AAAA, 0);
    @(negedge clock);
    #1;
    chk("exec_rf_load", rf_load, 1);
    chk("exec_wdata", rf_data_to_write, 'h2AAAA);
    reset = 1;
    #1;
    chk("rst_exec_strobes", {rf_enable, rf_load}, 0);
    chk("rst_exec_idle", cmd_ready, 1);
    #1;
    reset = 0;
    @(negedge clock);
    send(5, 12, 6, 0, 0, 1);
    wait_idle();
    chk("rst_exec_r6_kept", last_data, 'h155);
    send(6, 7, 0, 0, 7, 1);
    a1 = last_acc;
    send(0, 8, 7, 7, 0, 1);
    chk("b2b_spacing", last_acc - a1, 4);
    wait_idle();
    chk("b2b_data", last_data, 14);
    rand_ready = 1;
    repeat (80) begin
      send($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), longint'($urandom), 1);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
    end
    wait_idle();
    rand_ready = 0;
    resp_ready = 1;
    chk("cmp_never_loads", load_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
